// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing with registered, mutually aligned outputs
// Counters and outputs advance only on clk edges qualified by pix_ce and run.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = 11
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          pix_ce,
  input  logic          run,
  output logic          vga_h_sync,
  output logic          vga_v_sync,
  output logic          de,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start,
  output logic          vblank
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [CW-1:0] HT_M1 = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] VT_M1 = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] HA    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] VA    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_B  = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_E  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_B  = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_E  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 || CW < 1 || CW > 30 ||
      longint'(H_TOTAL - 1) >= (longint'(1) << CW) ||
      longint'(V_TOTAL - 1) >= (longint'(1) << CW)) begin : g_bad_params
    $error("vga_timing_gen: illegal timing parameters or CW too narrow");
  end

  logic [CW-1:0] r_hc, r_vc, r_x, r_y;
  logic          r_hs, r_vs, r_de, r_ls, r_fs, r_vb;
  logic          w_h_end, w_v_end, w_hs_act, w_vs_act;
  logic [CW-1:0] w_hc_nxt, w_vc_nxt;

  always_comb begin
    w_h_end  = r_hc == HT_M1;
    w_v_end  = r_vc == VT_M1;
    w_hc_nxt = w_h_end ? '0 : r_hc + CW'(1);
    w_vc_nxt = w_h_end ? (w_v_end ? '0 : r_vc + CW'(1)) : r_vc;
    w_hs_act = (r_hc >= HS_B) && (r_hc <= HS_E);
    w_vs_act = (r_vc >= VS_B) && (r_vc <= VS_E);
  end

  // Outputs describe the pre-increment pixel, so all signals share one pixel of latency.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_hc <= '0;
      r_vc <= '0;
      r_x  <= '0;
      r_y  <= '0;
      r_de <= 1'b0;
      r_vb <= 1'b0;
      r_ls <= 1'b0;
      r_fs <= 1'b0;
      r_hs <= ~HS_POL;
      r_vs <= ~VS_POL;
    end else if (!run) begin
      r_hc <= '0;
      r_vc <= '0;
      r_x  <= '0;
      r_y  <= '0;
      r_de <= 1'b0;
      r_vb <= 1'b0;
      r_ls <= 1'b0;
      r_fs <= 1'b0;
      r_hs <= ~HS_POL;
      r_vs <= ~VS_POL;
    end else if (pix_ce) begin
      r_hc <= w_hc_nxt;
      r_vc <= w_vc_nxt;
      r_x  <= r_hc;
      r_y  <= r_vc;
      r_de <= (r_hc < HA) && (r_vc < VA);
      r_vb <= r_vc >= VA;
      r_ls <= r_hc == '0;
      r_fs <= (r_hc == '0) && (r_vc == '0);
      r_hs <= w_hs_act ? HS_POL : ~HS_POL;
      r_vs <= w_vs_act ? VS_POL : ~VS_POL;
    end else begin
      r_ls <= 1'b0;
      r_fs <= 1'b0;
    end
  end

  assign vga_h_sync  = r_hs;
  assign vga_v_sync  = r_vs;
  assign de          = r_de;
  assign x           = r_x;
  assign y           = r_y;
  assign line_start  = r_ls;
  assign frame_start = r_fs;
  assign vblank      = r_vb;
endmodule
